// File: rtl/inst_queue_pkg.sv
// Shared constants and types for the instruction queue.
//   XLEN       : instruction / address width
//   INST_NOP   : canonical NOP (addi x0, x0, 0) shown when the queue is empty
//   IQ_DEPTH   : default number of queue entries (power of two, >= 2)
//   IQ_PTR_W   : log2(IQ_DEPTH), read/write pointer width
//   IQ_CNT_W   : IQ_PTR_W+1, occupancy counter width (must hold 0..DEPTH)
//   iq_entry_t : one stored {inst, addr} pair
package inst_queue_pkg;

  localparam int XLEN = 32;
  localparam logic [XLEN-1:0] INST_NOP = 32'h0000_0013;

  localparam int IQ_DEPTH = 4;
  localparam int IQ_PTR_W = 2;
  localparam int IQ_CNT_W = IQ_PTR_W + 1;

  typedef struct packed {
    logic [XLEN-1:0] inst;
    logic [XLEN-1:0] addr;
  } iq_entry_t;

endpackage

// File: rtl/inst_queue_ram.sv
// Storage array for the instruction queue: DEPTH x W registers with one
// synchronous write port and one asynchronous (combinational) read port.
// Contents are not reset; the pointer/count logic in inst_queue decides
// which entries are meaningful.
// Ports:
//   clk   : write clock
//   we    : write enable
//   waddr : write index
//   wdata : write data
//   raddr : read index
//   rdata : read data, combinational from raddr
module inst_queue_ram #(
  parameter int DEPTH = 4,
  parameter int PTR_W = 2,
  parameter int W     = 64
) (
  input  logic             clk,
  input  logic             we,
  input  logic [PTR_W-1:0] waddr,
  input  logic [W-1:0]     wdata,
  input  logic [PTR_W-1:0] raddr,
  output logic [W-1:0]     rdata
);

  logic [W-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) begin
      mem[waddr] <= wdata;
    end
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/inst_queue.sv
// Instruction queue between fetch and decode. Buffers fetched {inst, addr}
// pairs so decode stalls do not lose in-flight fetches, throttles fetch via
// pause, and drops everything on a jump flush.
//
// Handshake: on the input side an entry is offered whenever in_valid=1; it
// is taken at the rising edge unless flush=1 or the queue is full with no
// pop in the same cycle. Fetch is expected to honour pause, which rises one
// entry early to leave room for the fetch already in flight. On the output
// side the head transfers at the rising edge when out_valid=1 and
// out_ready=1; out_ready while out_valid=0 has no effect.
//
// Ports:
//   clk, rst           : clock, asynchronous active-low reset
//   flush              : jump taken; clears queue, discards same-cycle push
//   in_valid/inst/addr : fetched instruction offered this cycle
//   pause              : fetch must hold its pc while high
//   out_valid/inst/addr: queue head (NOP / 0 when empty)
//   out_ready          : decoder consumes the head this cycle
//   count              : current occupancy, 0..DEPTH
//   overflow           : sticky, a push was lost because the queue was full
module inst_queue
  import inst_queue_pkg::*;
#(
  parameter int DEPTH = IQ_DEPTH,
  parameter int PTR_W = IQ_PTR_W,
  parameter int CNT_W = IQ_CNT_W
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush,
  input  logic             in_valid,
  input  logic [XLEN-1:0]  in_inst,
  input  logic [XLEN-1:0]  in_addr,
  output logic             pause,
  output logic             out_valid,
  output logic [XLEN-1:0]  out_inst,
  output logic [XLEN-1:0]  out_addr,
  input  logic             out_ready,
  output logic [CNT_W-1:0] count,
  output logic             overflow
);

  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic             full;
  logic             pop;
  logic             push;
  iq_entry_t        wr_entry;
  iq_entry_t        rd_entry;

  assign full = (count == CNT_W'(DEPTH));
  assign pop  = out_valid & out_ready;
  // A full queue can still accept a push when the head leaves in the same cycle.
  assign push = in_valid & ~flush & (~full | pop);

  assign wr_entry.inst = in_inst;
  assign wr_entry.addr = in_addr;

  inst_queue_ram #(
    .DEPTH (DEPTH),
    .PTR_W (PTR_W),
    .W     ($bits(iq_entry_t))
  ) u_ram (
    .clk   (clk),
    .we    (push),
    .waddr (wr_ptr),
    .wdata (wr_entry),
    .raddr (rd_ptr),
    .rdata (rd_entry)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      overflow <= 1'b0;
    end else if (flush) begin
      // Flush wins over push/pop; overflow keeps its sticky value.
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + PTR_W'(1);
      end
      if (pop) begin
        rd_ptr <= rd_ptr + PTR_W'(1);
      end
      if (push && !pop) begin
        count <= count + CNT_W'(1);
      end else if (pop && !push) begin
        count <= count - CNT_W'(1);
      end
      if (in_valid && full && !pop) begin
        overflow <= 1'b1;
      end
    end
  end

  always_comb begin
    out_valid = (count != '0);
    out_inst  = INST_NOP;
    out_addr  = '0;
    if (out_valid) begin
      out_inst = rd_entry.inst;
      out_addr = rd_entry.addr;
    end
  end

  // One slot stays free for the fetch already issued when pause rises.
  assign pause = (count >= CNT_W'(DEPTH - 1));

endmodule
